// File: rtl/rapcore_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : rapcore_spi_master
//  Description : SPI initiator for the rapcore responder. Mode 0 (CPOL=0,
//                CPHA=0), MSB first, fixed word length. A word accepted with
//                tx_last=0 keeps CS asserted and waits for the next word, so
//                multi-word bursts go out under a single chip select.
//                Optional feature macro: RAPCORE_SPI_LOOPBACK_EN adds a
//                'loopback' input that feeds the receive shifter from the
//                internal COPI instead of spi_cipo.
//  Revision    : 1.0 - initial release
// ============================================================================
module rapcore_spi_master #(
    parameter int WORD_BITS = 64,
    parameter int CLK_DIV   = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_last,
    output logic                 rx_valid,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 busy,
    output logic                 spi_sck,
    output logic                 spi_cs_n,
    output logic                 spi_copi,
    input  logic                 spi_cipo
`ifdef RAPCORE_SPI_LOOPBACK_EN
    ,
    input  logic                 loopback
`endif
);

    // Divider width stays at least one bit so CLK_DIV=1 still elaborates.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] BITS_ALL  = CNT_W'(WORD_BITS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_SHIFT      = 3'd2,
        ST_HOLD       = 3'd3,
        ST_BURST_WAIT = 3'd4,
        ST_GAP        = 3'd5
    } state_t;

    state_t               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    // The MSB of each word goes straight to COPI at accept time, so the
    // transmit shifter only has to hold the remaining WORD_BITS-1 bits.
    logic [WORD_BITS-2:0] tx_sr_q;
    // The final received bit is merged in directly when rx_data is loaded,
    // so the receive shifter also only needs WORD_BITS-1 bits.
    logic [WORD_BITS-2:0] rx_sr_q;
    logic [WORD_BITS-1:0] rx_data_q;
    logic                 last_q;
    logic                 tx_ready_q;
    logic                 rx_valid_q;
    logic                 busy_q;
    logic                 sck_q;
    logic                 cs_n_q;
    logic                 copi_q;

    logic                 tick_w;
    logic                 accept_w;
    logic                 rx_bit_w;
    logic [WORD_BITS-1:0] rx_word_w;

    // A tick marks the end of one SCK half-period.
    assign tick_w   = (div_q == DIV_LAST);
    assign accept_w = tx_valid && tx_ready_q;

`ifdef RAPCORE_SPI_LOOPBACK_EN
    // In loopback the pins keep toggling; only the receive source changes.
    assign rx_bit_w = loopback ? copi_q : spi_cipo;
`else
    assign rx_bit_w = spi_cipo;
`endif

    assign rx_word_w = {rx_sr_q, rx_bit_w};

    // Half-period divider: parked at zero in IDLE, and restarted on every
    // accepted word so the first SHIFT half-period is always full length.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q <= '0;
        end else if (state_q == ST_IDLE || accept_w || tick_w) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Transfer sequencer; every pin and handshake output is a register here.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            copi_q     <= 1'b0;
            // A reset that aborts a transfer keeps the last completed word;
            // once the block is idle (any reset held past one cycle, such as
            // power-on) the received word is cleared.
            if (!busy_q) begin
                rx_data_q <= '0;
            end
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        tx_sr_q    <= tx_data[WORD_BITS-2:0];
                        copi_q     <= tx_data[WORD_BITS-1];
                        last_q     <= tx_last;
                        bit_cnt_q  <= '0;
                        rx_sr_q    <= '0;
                        cs_n_q     <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (tick_w) begin
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (tick_w) begin
                        if (!sck_q) begin
                            // Rising edge: sample the responder.
                            sck_q     <= 1'b1;
                            rx_sr_q   <= rx_word_w[WORD_BITS-2:0];
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == BITS_LAST) begin
                                rx_data_q  <= rx_word_w;
                                rx_valid_q <= 1'b1;
                            end
                        end else begin
                            // Falling edge: present the next bit, or finish.
                            sck_q <= 1'b0;
                            if (bit_cnt_q == BITS_ALL) begin
                                state_q <= ST_HOLD;
                            end else begin
                                copi_q  <= tx_sr_q[WORD_BITS-2];
                                tx_sr_q <= {tx_sr_q[WORD_BITS-3:0], 1'b0};
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    if (tick_w) begin
                        if (last_q) begin
                            cs_n_q  <= 1'b1;
                            copi_q  <= 1'b0;
                            state_q <= ST_GAP;
                        end else begin
                            tx_ready_q <= 1'b1;
                            state_q    <= ST_BURST_WAIT;
                        end
                    end
                end

                ST_BURST_WAIT: begin
                    // CS stays low indefinitely until the next burst word.
                    if (accept_w) begin
                        tx_sr_q    <= tx_data[WORD_BITS-2:0];
                        copi_q     <= tx_data[WORD_BITS-1];
                        last_q     <= tx_last;
                        bit_cnt_q  <= '0;
                        tx_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end

                ST_GAP: begin
                    // Guarantees the minimum CS-high time between frames.
                    if (tick_w) begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    sck_q      <= 1'b0;
                    cs_n_q     <= 1'b1;
                    copi_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    assign spi_copi = copi_q;

endmodule
`default_nettype wire

// File: tb/tb_rapcore_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rapcore_spi_master
//  Description : Directed bench for rapcore_spi_master. Instance A uses
//                WORD_BITS=8/CLK_DIV=2 with a Mode 0 responder model;
//                instance B uses WORD_BITS=64/CLK_DIV=1 with an echo responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rapcore_spi_master;

    localparam int WB  = 8;
    localparam int CD  = 2;
    localparam int WB2 = 64;
    localparam int CD2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A signals
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic          tx_last = 1'b0;
    logic [WB-1:0] tx_data = '0;
    logic          tx_ready, rx_valid, busy, sck, cs_n, copi, cipo;
    logic [WB-1:0] rx_data;

    // Instance B signals
    logic           rst2 = 1'b1;
    logic           tx_valid2 = 1'b0;
    logic           tx_last2 = 1'b0;
    logic [WB2-1:0] tx_data2 = '0;
    logic           tx_ready2, rx_valid2, busy2, sck2, cs_n2, copi2, cipo2;
    logic [WB2-1:0] rx_data2;

    // Mode 0 responder model for instance A
    logic [WB-1:0] resp_word = 8'h00;
    logic [WB-1:0] resp_sr = '0;
    logic [WB-1:0] cap_sr = '0;
    int            resp_bits = 0;
    int            sck_rises = 0;
    int            cs_falls = 0;
    int            cs_rises = 0;

`ifdef RAPCORE_SPI_LOOPBACK_EN
    logic loopback = 1'b0;
    assign cipo = loopback ? 1'b0 : resp_sr[WB-1];
`else
    assign cipo = resp_sr[WB-1];
`endif

    // Echo responder for instance B
    assign cipo2 = copi2;

    rapcore_spi_master #(.WORD_BITS(WB), .CLK_DIV(CD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .spi_sck  (sck),
        .spi_cs_n (cs_n),
        .spi_copi (copi),
        .spi_cipo (cipo)
`ifdef RAPCORE_SPI_LOOPBACK_EN
        ,
        .loopback (loopback)
`endif
    );

    rapcore_spi_master #(.WORD_BITS(WB2), .CLK_DIV(CD2)) dut2 (
        .wb_clk_i (clk),
        .wb_rst_i (rst2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .tx_data  (tx_data2),
        .tx_last  (tx_last2),
        .rx_valid (rx_valid2),
        .rx_data  (rx_data2),
        .busy     (busy2),
        .spi_sck  (sck2),
        .spi_cs_n (cs_n2),
        .spi_copi (copi2),
        .spi_cipo (cipo2)
`ifdef RAPCORE_SPI_LOOPBACK_EN
        ,
        .loopback (1'b0)
`endif
    );

    // Responder: load on CS fall, capture COPI on rise, shift on fall,
    // reload the next response word after each full word.
    always @(negedge cs_n) begin
        resp_sr   = resp_word;
        resp_bits = 0;
        cs_falls++;
    end
    always @(posedge cs_n) cs_rises++;
    always @(posedge sck) begin
        cap_sr = {cap_sr[WB-2:0], copi};
        sck_rises++;
    end
    always @(negedge sck) begin
        if (!cs_n) begin
            resp_bits++;
            if (resp_bits == WB) begin
                resp_sr   = resp_word;
                resp_bits = 0;
            end else begin
                resp_sr = {resp_sr[WB-2:0], 1'b0};
            end
        end
    end

    // Per-cycle event counters sampled mid-cycle
    int rxv_cnt = 0;
    int csl_cnt = 0;
    int rxv2    = 0;
    int csl2    = 0;
    int sckhi2  = 0;
    always @(negedge clk) begin
        if (rx_valid)  rxv_cnt++;
        if (!cs_n)     csl_cnt++;
        if (rx_valid2) rxv2++;
        if (!cs_n2)    csl2++;
        if (sck2)      sckhi2++;
    end

    task automatic send(input logic [WB-1:0] d, input logic last, output bit ok);
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rxv(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_high(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (cs_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sck !== 1'b0)      begin errors++; $display("FAIL reset_sck: got %b expected 0", sck); end
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
        checks++; if (copi !== 1'b0)     begin errors++; $display("FAIL reset_copi: got %b expected 0", copi); end
        checks++; if (cs_n2 !== 1'b1)    begin errors++; $display("FAIL reset_cs_n2: got %b expected 1", cs_n2); end
        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_tx_ready: got %b expected 1", tx_ready); end
    endtask

    task automatic test_single();
        bit ok;
        int rx0, cl0;
        resp_word = 8'h3C;
        rx0 = rxv_cnt;
        cl0 = csl_cnt;
        send(8'hA5, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_accept: tx_ready never 1"); end
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_rxv_timeout: rx_valid never 1"); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h expected 3c", rx_data); end
        checks++; if (cap_sr !== 8'hA5)  begin errors++; $display("FAIL single_copi_bits: got %h expected a5", cap_sr); end
        wait_cs_high(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_cs_timeout: cs_n never 1"); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_gap0: got %b expected 0", tx_ready); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_ready_gap1: got %b expected 0", tx_ready); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_back: got %b expected 1", tx_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        checks++; if (csl_cnt - cl0 !== 36) begin errors++; $display("FAIL single_cs_low_cycles: got %0d expected 36", csl_cnt - cl0); end
        checks++; if (rxv_cnt - rx0 !== 1)  begin errors++; $display("FAIL single_rxv_pulses: got %0d expected 1", rxv_cnt - rx0); end
    endtask

    task automatic test_burst();
        bit ok;
        int rx0, cf0, cr0, bad;
        resp_word = 8'h5E;
        rx0 = rxv_cnt;
        cf0 = cs_falls;
        cr0 = cs_rises;
        send(8'h12, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_accept0: tx_ready never 1"); end
        resp_word = 8'h6B;
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_rxv0_timeout: rx_valid never 1"); end
        checks++; if (rx_data !== 8'h5E) begin errors++; $display("FAIL burst_rx0: got %h expected 5e", rx_data); end
        checks++; if (cap_sr !== 8'h12)  begin errors++; $display("FAIL burst_copi0: got %h expected 12", cap_sr); end
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_wait_ready: tx_ready never 1"); end
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL burst_cs_held: got %b expected 0", cs_n); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sck !== 1'b0 || cs_n !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL burst_wait_idle_pins: got %0d bad cycles expected 0", bad); end
        send(8'h34, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_accept1: tx_ready never 1"); end
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_rxv1_timeout: rx_valid never 1"); end
        checks++; if (rx_data !== 8'h6B) begin errors++; $display("FAIL burst_rx1: got %h expected 6b", rx_data); end
        checks++; if (cap_sr !== 8'h34)  begin errors++; $display("FAIL burst_copi1: got %h expected 34", cap_sr); end
        wait_cs_high(ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_cs_timeout: cs_n never 1"); end
        checks++; if (cs_falls - cf0 !== 1) begin errors++; $display("FAIL burst_cs_falls: got %0d expected 1", cs_falls - cf0); end
        checks++; if (cs_rises - cr0 !== 1) begin errors++; $display("FAIL burst_cs_rises: got %0d expected 1", cs_rises - cr0); end
        checks++; if (rxv_cnt - rx0 !== 2)  begin errors++; $display("FAIL burst_rxv_pulses: got %0d expected 2", rxv_cnt - rx0); end
        wait_ready(ok);
    endtask

    task automatic test_backpressure();
        bit ok, seen;
        int bad, highs;
        resp_word = 8'h99;
        send(8'h00, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept: tx_ready never 1"); end
        tx_data  = 8'hFF;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        bad  = 0;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!cs_n && tx_ready) bad++;
            if (rx_valid) begin
                seen = 1'b1;
                checks++; if (cap_sr !== 8'h00)  begin errors++; $display("FAIL bp_copi0: got %h expected 00", cap_sr); end
                checks++; if (rx_data !== 8'h99) begin errors++; $display("FAIL bp_rx0: got %h expected 99", rx_data); end
                resp_word = 8'h42;
            end
            if (cs_n) break;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_rxv_timeout: rx_valid never 1"); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_ready_while_busy: got %0d cycles expected 0", bad); end
        highs = 1;
        for (int t = 0; t < 20 && cs_n; t++) begin
            @(negedge clk);
            if (cs_n) highs++;
        end
        tx_valid = 1'b0;
        checks++; if (highs !== 3) begin errors++; $display("FAIL bp_cs_high_cycles: got %0d expected 3", highs); end
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rxv1_timeout: rx_valid never 1"); end
        checks++; if (cap_sr !== 8'hFF)  begin errors++; $display("FAIL bp_copi1: got %h expected ff", cap_sr); end
        checks++; if (rx_data !== 8'h42) begin errors++; $display("FAIL bp_rx1: got %h expected 42", rx_data); end
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_idle_timeout: tx_ready never 1"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r0, rx0;
        resp_word = 8'h77;
        r0  = sck_rises;
        rx0 = rxv_cnt;
        send(8'hC3, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_accept: tx_ready never 1"); end
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (sck_rises - r0 == 4) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL rmid_rise4_timeout: got %0d rises expected 4", sck_rises - r0); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cs_n !== 1'b1)     begin errors++; $display("FAIL rmid_cs_n: got %b expected 1", cs_n); end
        checks++; if (sck !== 1'b0)      begin errors++; $display("FAIL rmid_sck: got %b expected 0", sck); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 8'h42) begin errors++; $display("FAIL rmid_rx_kept: got %h expected 42", rx_data); end
        repeat (20) @(negedge clk);
        checks++; if (rxv_cnt - rx0 !== 0) begin errors++; $display("FAIL rmid_no_rxv: got %0d pulses expected 0", rxv_cnt - rx0); end
        checks++; if (cs_n !== 1'b1)       begin errors++; $display("FAIL rmid_stays_idle: cs_n got %b expected 1", cs_n); end
        resp_word = 8'hE7;
        send(8'h81, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_accept2: tx_ready never 1"); end
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_rxv2_timeout: rx_valid never 1"); end
        checks++; if (rx_data !== 8'hE7) begin errors++; $display("FAIL rmid_rx2: got %h expected e7", rx_data); end
        checks++; if (cap_sr !== 8'h81)  begin errors++; $display("FAIL rmid_copi2: got %h expected 81", cap_sr); end
        wait_ready(ok);
    endtask

    task automatic test_wide();
        bit ok;
        int cl0, hi0, rx0;
        cl0 = csl2;
        hi0 = sckhi2;
        rx0 = rxv2;
        tx_data2  = 64'h0123_4567_89AB_CDEF;
        tx_last2  = 1'b1;
        tx_valid2 = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (tx_ready2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid2 = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL wide_accept: tx_ready2 never 1"); end
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (rx_valid2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wide_rxv_timeout: rx_valid2 never 1"); end
        checks++; if (rx_data2 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wide_rx_data: got %h expected 0123456789abcdef", rx_data2); end
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (cs_n2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wide_cs_timeout: cs_n2 never 1"); end
        checks++; if (csl2 - cl0 !== 130)  begin errors++; $display("FAIL wide_cs_low_cycles: got %0d expected 130", csl2 - cl0); end
        checks++; if (sckhi2 - hi0 !== 64) begin errors++; $display("FAIL wide_sck_high_cycles: got %0d expected 64", sckhi2 - hi0); end
        checks++; if (rxv2 - rx0 !== 1)    begin errors++; $display("FAIL wide_rxv_pulses: got %0d expected 1", rxv2 - rx0); end
    endtask

`ifdef RAPCORE_SPI_LOOPBACK_EN
    task automatic test_loopback();
        bit ok;
        loopback = 1'b1;
        send(8'h5A, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lb_accept: tx_ready never 1"); end
        wait_rxv(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lb_rxv_timeout: rx_valid never 1"); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL lb_rx_data: got %h expected 5a", rx_data); end
        wait_ready(ok);
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_reset_mid();
        test_wide();
`ifdef RAPCORE_SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
